// File: rtl/rx_pkg.sv
// Shared types and defaults for the receive path: timestamp run records and
// the reconstructor state encoding.
package rx_pkg;

  localparam int SAMPLE_WIDTH     = 12;
  localparam int PARALLEL_SAMPLES = 4;

  // One saved run: first output word index and number of words in the run.
  typedef struct packed {
    logic [31:0] start_index;
    logic [15:0] word_count;
  } tstamp_rec_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    FILL  = 3'd2,
    COPY  = 3'd3,
    TAIL  = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/sample_reconstructor.sv
// Rebuilds a dense stream of total_words output words from sparse saved runs,
// padding the gaps between runs with a replicated fill sample.
module sample_reconstructor #(
  parameter int SAMPLE_WIDTH     = rx_pkg::SAMPLE_WIDTH,
  parameter int PARALLEL_SAMPLES = rx_pkg::PARALLEL_SAMPLES,
  parameter int INDEX_BITS       = 32,
  parameter int COUNT_BITS       = 16,
  localparam int DWIDTH          = SAMPLE_WIDTH * PARALLEL_SAMPLES
) (
  input  logic                           adc_clk,
  input  logic                           adc_reset,
  input  logic                           start,
  input  logic [INDEX_BITS-1:0]          total_words,
  input  logic [SAMPLE_WIDTH-1:0]        fill_value,
  input  logic                           flush,
  input  logic [INDEX_BITS+COUNT_BITS-1:0] tstamp_in_data,
  input  logic                           tstamp_in_valid,
  output logic                           tstamp_in_ready,
  input  logic [DWIDTH-1:0]              data_in_data,
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  output logic [DWIDTH-1:0]              data_out_data,
  output logic                           data_out_valid,
  input  logic                           data_out_ready,
  output logic                           data_out_last,
  output logic                           busy,
  output logic                           done,
  output logic                           overlap_error,
  output logic [2:0]                     o_dbg_state
);
  import rx_pkg::*;

  // Every port pair is valid/ready: a word moves only on a rising edge where
  // both are high; valid never waits on ready, and ready may depend on valid.

  state_e                  r_state, w_next;
  logic [INDEX_BITS-1:0]   r_total, r_out_index, r_start_idx;
  logic [SAMPLE_WIDTH-1:0] r_fill;
  logic [COUNT_BITS-1:0]   r_count, r_skip;
  logic                    r_drain, r_flush_seen, r_overlap;

  logic [INDEX_BITS-1:0]   w_rec_start, w_diff, w_cnt_ext;
  logic [COUNT_BITS-1:0]   w_rec_count, w_skip_init;
  logic [INDEX_BITS:0]     w_idx_inc;
  logic                    w_at_end, w_last_word, w_flush, w_skipping;
  logic                    w_tin_fire, w_out_fire;

  assign w_rec_start = tstamp_in_data[INDEX_BITS+COUNT_BITS-1:COUNT_BITS];
  assign w_rec_count = tstamp_in_data[COUNT_BITS-1:0];
  assign w_diff      = r_out_index - w_rec_start;
  assign w_cnt_ext   = INDEX_BITS'(w_rec_count);
  // Words of an overlapping run that precede out_index are dropped, capped at the run length.
  assign w_skip_init = (w_diff >= w_cnt_ext) ? w_rec_count : w_diff[COUNT_BITS-1:0];
  assign w_idx_inc   = {1'b0, r_out_index} + 1'b1;
  assign w_at_end    = (r_out_index == r_total);
  assign w_last_word = (w_idx_inc == {1'b0, r_total});
  assign w_flush     = flush | r_flush_seen;
  assign w_skipping  = (r_skip != '0);
  assign w_tin_fire  = tstamp_in_valid & tstamp_in_ready;
  assign w_out_fire  = data_out_valid & data_out_ready;

  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);
  assign overlap_error = r_overlap;
  assign o_dbg_state   = r_state;

  always_comb begin
    w_next          = r_state;
    tstamp_in_ready = 1'b0;
    data_in_ready   = 1'b0;
    data_out_valid  = 1'b0;
    data_out_last   = 1'b0;
    data_out_data   = {PARALLEL_SAMPLES{r_fill}};
    case (r_state)
      IDLE: if (start) w_next = FETCH;
      FETCH: begin
        if (w_at_end) begin
          w_next = DONE;
        end else begin
          tstamp_in_ready = 1'b1;
          if (tstamp_in_valid) begin
            if (w_rec_count == '0)             w_next = FETCH;
            else if (w_rec_start > r_out_index) w_next = FILL;
            else                                w_next = COPY;
          end else if (w_flush) begin
            w_next = TAIL;
          end
        end
      end
      FILL: begin
        data_out_valid = 1'b1;
        data_out_last  = w_last_word;
        if (data_out_ready) begin
          if (w_last_word)                                  w_next = DONE;
          else if (w_idx_inc[INDEX_BITS-1:0] == r_start_idx) w_next = COPY;
        end
      end
      COPY: begin
        if (w_skipping) begin
          data_in_ready = 1'b1;
          if (data_in_valid && r_count == COUNT_BITS'(1)) w_next = r_drain ? DONE : FETCH;
        end else begin
          data_out_data  = data_in_data;
          data_out_valid = data_in_valid;
          data_in_ready  = data_out_ready;
          data_out_last  = w_last_word;
          if (data_in_valid && data_out_ready) begin
            if (w_last_word)                   w_next = (r_count == COUNT_BITS'(1)) ? DONE : COPY;
            else if (r_count == COUNT_BITS'(1)) w_next = FETCH;
          end
        end
      end
      TAIL: begin
        data_out_valid = 1'b1;
        data_out_last  = w_last_word;
        if (data_out_ready && w_last_word) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_reset) begin
      r_state      <= IDLE;
      r_total      <= '0;
      r_fill       <= '0;
      r_out_index  <= '0;
      r_start_idx  <= '0;
      r_count      <= '0;
      r_skip       <= '0;
      r_drain      <= 1'b0;
      r_flush_seen <= 1'b0;
      r_overlap    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DONE)                r_flush_seen <= 1'b0;
      else if (flush && r_state != IDLE)  r_flush_seen <= 1'b1;
      case (r_state)
        IDLE: if (start) begin
          r_total     <= total_words;
          r_fill      <= fill_value;
          r_out_index <= '0;
          r_overlap   <= 1'b0;
          r_drain     <= 1'b0;
          r_skip      <= '0;
        end
        FETCH: if (w_tin_fire) begin
          r_start_idx <= w_rec_start;
          r_count     <= w_rec_count;
          r_drain     <= 1'b0;
          if (w_rec_count != '0 && w_rec_start < r_out_index) begin
            r_overlap <= 1'b1;
            r_skip    <= w_skip_init;
          end else begin
            r_skip    <= '0;
          end
        end
        FILL, TAIL: if (w_out_fire) r_out_index <= w_idx_inc[INDEX_BITS-1:0];
        COPY: begin
          if (w_skipping) begin
            if (data_in_valid) begin
              r_count <= r_count - 1'b1;
              r_skip  <= r_skip - 1'b1;
            end
          end else if (w_out_fire) begin
            r_out_index <= w_idx_inc[INDEX_BITS-1:0];
            r_count     <= r_count - 1'b1;
            // Output is full but the run is not: swallow its remaining words.
            if (w_last_word && r_count != COUNT_BITS'(1)) begin
              r_drain   <= 1'b1;
              r_skip    <= r_count - 1'b1;
              r_overlap <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_reconstructor.sv
// Self-checking bench for sample_reconstructor: directed vector table,
// multi-cycle corner sequences and randomized runs against a reference model.
module tb_sample_reconstructor;
  import rx_pkg::*;

  localparam int SW = 12;
  localparam int PS = 4;
  localparam int DW = SW * PS;

  logic          adc_clk = 1'b0;
  logic          adc_reset, start, flush;
  logic [31:0]   total_words;
  logic [SW-1:0] fill_value;
  logic [47:0]   tstamp_in_data;
  logic          tstamp_in_valid, tstamp_in_ready;
  logic [DW-1:0] data_in_data;
  logic          data_in_valid, data_in_ready;
  logic [DW-1:0] data_out_data;
  logic          data_out_valid, data_out_ready, data_out_last;
  logic          busy, done, overlap_error;
  logic [2:0]    dbg_state;

  sample_reconstructor dut (
    .adc_clk(adc_clk), .adc_reset(adc_reset), .start(start),
    .total_words(total_words), .fill_value(fill_value), .flush(flush),
    .tstamp_in_data(tstamp_in_data), .tstamp_in_valid(tstamp_in_valid),
    .tstamp_in_ready(tstamp_in_ready),
    .data_in_data(data_in_data), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .data_out_data(data_out_data), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_out_last(data_out_last),
    .busy(busy), .done(done), .overlap_error(overlap_error),
    .o_dbg_state(dbg_state)
  );

  always #5 adc_clk = ~adc_clk;

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;

  int            c_total, c_nrec;
  logic [SW-1:0] c_fill;
  int            c_rs[8];
  int            c_rc[8];
  logic [DW-1:0] d_words[$];
  logic [DW-1:0] exp_q[$];
  int            m_consumed, m_recs;
  bit            m_ovl;
  int            got_cons;
  bit            got_ovl;

  typedef struct packed {
    int            total;
    logic [SW-1:0] fill;
    int            n_rec;
    logic [1:0][31:0] rs;
    logic [1:0][15:0] rc;
    bit            rr;
    bit            exp_ovl;
    int            exp_cons;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk_vec(input int total, input logic [SW-1:0] fill, input int n,
                                  input int s0, input int k0, input int s1, input int k1,
                                  input bit rr, input bit ovl, input int cons);
    vec_t v;
    v.total = total; v.fill = fill; v.n_rec = n;
    v.rs[0] = 32'(s0); v.rc[0] = 16'(k0);
    v.rs[1] = 32'(s1); v.rc[1] = 16'(k1);
    v.rr = rr; v.exp_ovl = ovl; v.exp_cons = cons;
    return v;
  endfunction

  task automatic gen_data();
    int sum;
    sum = 0;
    d_words.delete();
    for (int r = 0; r < c_nrec; r++) sum += c_rc[r];
    for (int k = 0; k < sum; k++) d_words.push_back(DW'({$urandom(), $urandom()}));
  endtask

  task automatic load_vec(input vec_t v);
    c_total = v.total; c_fill = v.fill; c_nrec = v.n_rec;
    c_rs[0] = int'(v.rs[0]); c_rc[0] = int'(v.rc[0]);
    c_rs[1] = int'(v.rs[1]); c_rc[1] = int'(v.rc[1]);
    gen_data();
  endtask

  // Reference: walk the runs in order, padding with fill up to each run's start,
  // dropping words that fall before the current position, stopping at total.
  task automatic build_model();
    int n, di, s, c, skip;
    logic [DW-1:0] fw;
    fw = {PS{c_fill}};
    exp_q.delete();
    m_ovl = 1'b0; m_recs = 0; n = 0; di = 0;
    for (int r = 0; r < c_nrec; r++) begin
      if (n >= c_total) break;
      m_recs++;
      s = c_rs[r]; c = c_rc[r];
      if (c == 0) continue;
      while (n < s && n < c_total) begin exp_q.push_back(fw); n++; end
      if (n >= c_total) break;
      skip = (n > s) ? n - s : 0;
      if (skip > c) skip = c;
      if (skip > 0) m_ovl = 1'b1;
      di += skip;
      for (int k = skip; k < c; k++) begin
        if (n < c_total) begin exp_q.push_back(d_words[di]); n++; end
        else m_ovl = 1'b1;
        di++;
      end
    end
    while (n < c_total) begin exp_q.push_back(fw); n++; end
    m_consumed = di;
  endtask

  // Drives one reconstruction: records, data and flush from the current case,
  // random source gaps, optional random sink back-pressure.
  task automatic run_case(input bit rr);
    int t_ptr, d_ptr, n_out, n_extra;
    bit t_hold, d_hold, flush_sent, done_seen;
    logic [DW-1:0] exp_w;
    tstamp_rec_t rec;
    t_ptr = 0; d_ptr = 0; n_out = 0; n_extra = 0;
    t_hold = 0; d_hold = 0; flush_sent = 0; done_seen = 0;
    build_model();
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      @(negedge adc_clk);
      // A second start mid-run and changing total/fill must be ignored.
      start = (cyc == 0) || (cyc == 3);
      if (cyc == 0) begin total_words = 32'(c_total); fill_value = c_fill; end
      else begin total_words = $urandom(); fill_value = SW'($urandom()); end
      if (!t_hold) begin
        if (t_ptr < c_nrec && $urandom_range(0, 3) != 0) begin
          rec.start_index = 32'(c_rs[t_ptr]);
          rec.word_count  = 16'(c_rc[t_ptr]);
          tstamp_in_data  = rec;
          tstamp_in_valid = 1'b1;
        end else tstamp_in_valid = 1'b0;
      end
      flush = 1'b0;
      if (!flush_sent && cyc >= 1 && t_ptr == c_nrec) begin flush = 1'b1; flush_sent = 1; end
      if (!d_hold) begin
        if (d_ptr < d_words.size() && $urandom_range(0, 3) != 0) begin
          data_in_data  = d_words[d_ptr];
          data_in_valid = 1'b1;
        end else data_in_valid = 1'b0;
      end
      data_out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (tstamp_in_valid && tstamp_in_ready) begin t_ptr++; t_hold = 0; end
      else t_hold = tstamp_in_valid;
      if (data_in_valid && data_in_ready) begin d_ptr++; d_hold = 0; end
      else d_hold = data_in_valid;
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) n_extra++;
        else begin
          exp_w = exp_q.pop_front();
          check($sformatf("word%0d", n_out), 64'(data_out_data), 64'(exp_w));
        end
        check($sformatf("last%0d", n_out), 64'(data_out_last), 64'(n_out == c_total - 1));
        n_out++;
      end
      if (done) done_seen = 1;
    end
    check("done_seen", 64'(done_seen), 64'(1));
    @(negedge adc_clk);
    start = 1'b0; flush = 1'b0; tstamp_in_valid = 1'b0; data_in_valid = 1'b0;
    data_out_ready = 1'b0; total_words = '0;
    #1;
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_after_done", 64'(busy), 64'(0));
    check("out_count", 64'(n_out + n_extra), 64'(c_total));
    check("data_consumed", 64'(d_ptr), 64'(m_consumed));
    check("recs_consumed", 64'(t_ptr), 64'(m_recs));
    check("overlap", 64'(overlap_error), 64'(m_ovl));
    got_cons = d_ptr;
    got_ovl  = overlap_error;
  endtask

  initial begin
    bit hit, t_fired;
    int pos, s, k;
    adc_reset = 1'b1; start = 1'b0; flush = 1'b0; total_words = '0; fill_value = '0;
    tstamp_in_data = '0; tstamp_in_valid = 1'b0; data_in_data = '0; data_in_valid = 1'b0;
    data_out_ready = 1'b0;

    //                total fill    n  s0 c0 s1  c1 rr ovl cons
    vecs[0] = mk_vec(16, 12'h5A5, 2,  4, 3, 10, 2, 0, 0, 5);
    vecs[1] = mk_vec(16, 12'h5A5, 2,  4, 3, 10, 2, 1, 0, 5);
    vecs[2] = mk_vec(10, 12'h0F0, 2,  2, 4,  4, 2, 0, 1, 6);
    vecs[3] = mk_vec( 8, 12'hABC, 1,  6, 5,  0, 0, 1, 1, 5);
    vecs[4] = mk_vec( 4, 12'h321, 1,  0, 0,  0, 0, 0, 0, 0);
    vecs[5] = mk_vec( 5, 12'h777, 1,  8, 2,  0, 0, 1, 0, 0);
    vecs[6] = mk_vec( 6, 12'h111, 1,  0, 6,  0, 0, 0, 0, 6);
    vecs[7] = mk_vec( 0, 12'hFFF, 1,  3, 2,  0, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(negedge adc_clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_overlap", 64'(overlap_error), 64'(0));
    check("rst_out_valid", 64'(data_out_valid), 64'(0));
    check("rst_ts_ready", 64'(tstamp_in_ready), 64'(0));
    check("rst_din_ready", 64'(data_in_ready), 64'(0));
    @(negedge adc_clk);
    adc_reset = 1'b0;

    // total_words == 0: done two cycles after start
    @(negedge adc_clk);
    start = 1'b1; total_words = '0;
    @(negedge adc_clk);
    start = 1'b0;
    #1 check("zero_total_done_c1", 64'(done), 64'(0));
    @(negedge adc_clk);
    #1 check("zero_total_done_c2", 64'(done), 64'(1));
    check("zero_total_no_out", 64'(data_out_valid), 64'(0));
    @(negedge adc_clk);
    #1 check("zero_total_done_c3", 64'(done), 64'(0));
    check("zero_total_idle", 64'(busy), 64'(0));

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      load_vec(vecs[i]);
      run_case(vecs[i].rr);
      check($sformatf("vec%0d_overlap", i), 64'(got_ovl), 64'(vecs[i].exp_ovl));
      check($sformatf("vec%0d_consumed", i), 64'(got_cons), 64'(vecs[i].exp_cons));
    end

    // Reset asserted while copying a run
    @(negedge adc_clk);
    start = 1'b1; total_words = 32'd16; fill_value = 12'h123;
    tstamp_in_data = {32'd4, 16'd3}; tstamp_in_valid = 1'b1;
    data_in_data = DW'({$urandom(), $urandom()}); data_in_valid = 1'b1; data_out_ready = 1'b1;
    hit = 0; t_fired = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge adc_clk);
      start = 1'b0;
      if (t_fired) tstamp_in_valid = 1'b0;
      #1;
      if (tstamp_in_valid && tstamp_in_ready) t_fired = 1;
      if (data_out_valid && data_in_ready) hit = 1;
    end
    check("reset_copy_reached", 64'(hit), 64'(1));
    adc_reset = 1'b1;
    @(negedge adc_clk);
    adc_reset = 1'b0; tstamp_in_valid = 1'b0; data_in_valid = 1'b0;
    #1;
    check("copy_rst_busy", 64'(busy), 64'(0));
    check("copy_rst_out_valid", 64'(data_out_valid), 64'(0));
    check("copy_rst_din_ready", 64'(data_in_ready), 64'(0));
    check("copy_rst_ts_ready", 64'(tstamp_in_ready), 64'(0));
    check("copy_rst_done", 64'(done), 64'(0));
    load_vec(vecs[0]);
    run_case(1'b0);

    // Randomized runs
    for (int t = 0; t < 24; t++) begin
      c_total = $urandom_range(0, 40);
      c_fill  = SW'($urandom());
      c_nrec  = $urandom_range(0, 4);
      pos = 0;
      for (int r = 0; r < c_nrec; r++) begin
        s = $urandom_range(0, pos + 8);
        k = $urandom_range(0, 6);
        c_rs[r] = s; c_rc[r] = k;
        pos = s + k;
      end
      gen_data();
      run_case(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
